// File: rtl/tamagotchi_input_conditioner.sv
// -----------------------------------------------------------------------------
// tamagotchi_input_conditioner
//
// This block sits in front of the pet-state FSM. It turns raw board inputs into
// clean single-cycle pulses on clk and runs the HC-SR04 ultrasonic ranging
// cycle.
//
// Ports:
//   clk           in   system clock (50 MHz)
//   rst           in   synchronous reset, active-low
//   btn_feed_n    in   raw feed button, 0 = pressed
//   btn_heal_n    in   raw heal button, 0 = pressed
//   btn_state_n   in   raw select-stat button, 0 = pressed
//   btn_test_n    in   raw test-mode toggle button, 0 = pressed
//   ldr_dark      in   raw photoresistor comparator, 1 = dark
//   us_echo       in   raw ultrasonic echo
//   us_trig       out  ultrasonic trigger, high for TRIG_CYCLES per measurement
//   feeding       out  one-cycle pulse on feed press
//   healing       out  one-cycle pulse on heal press
//   change_state  out  one-cycle pulse on select press
//   test          out  one-cycle pulse on test press
//   light_out     out  one-cycle pulse per completed dark hold period
//   echo_sig      out  one-cycle pulse when the result goes from far to near
//   near_flag     out  level holding the result of the last measurement
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// tamagotchi_debounce
//
// Debounces one synchronized active-low button. It emits a one-cycle pulse in
// the cycle after the debounced state changes from released to pressed.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active-low
//   btnSync     in   synchronized button level, 0 = pressed
//   pressPulse  out  one-cycle press pulse
// -----------------------------------------------------------------------------
module tamagotchi_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btnSync,
  output logic pressPulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             stable;      // accepted level, 1 = released
  logic             stablePrev;  // stable delayed one cycle, for edge detection
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so that every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stable     <= 1'b1;
      stablePrev <= 1'b1;
      cnt        <= '0;
      pressPulse <= 1'b0;
    end else begin
      stablePrev <= stable;
      pressPulse <= stablePrev & ~stable;
      if (btnSync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= btnSync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module tamagotchi_input_conditioner #(
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int LIGHT_HOLD_CYCLES   = 25000000,
  parameter int TRIG_CYCLES         = 500,
  parameter int MEAS_PERIOD_CYCLES  = 3000000,
  parameter int ECHO_TIMEOUT_CYCLES = 1500000,
  parameter int NEAR_THRESH_CYCLES  = 29000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_feed_n,
  input  logic btn_heal_n,
  input  logic btn_state_n,
  input  logic btn_test_n,
  input  logic ldr_dark,
  input  logic us_echo,
  output logic us_trig,
  output logic feeding,
  output logic healing,
  output logic change_state,
  output logic test,
  output logic light_out,
  output logic echo_sig,
  output logic near_flag
);

  // ---------------------------------------------------------------------------
  // Input synchronizers. Bit order: feed, heal, state, test, ldr, echo.
  // The reset value is the inactive level of each input.
  // ---------------------------------------------------------------------------
  localparam logic [5:0] SYNC_IDLE = 6'b00_1111;

  logic [5:0] rawIn;
  logic [5:0] syncMeta;
  logic [5:0] syncOut;

  assign rawIn = {us_echo, ldr_dark, btn_test_n, btn_state_n, btn_heal_n, btn_feed_n};

  always_ff @(posedge clk) begin
    if (!rst) begin
      syncMeta <= SYNC_IDLE;
      syncOut  <= SYNC_IDLE;
    end else begin
      syncMeta <= rawIn;
      syncOut  <= syncMeta;
    end
  end

  logic ldrSync;
  logic echoSync;

  assign ldrSync  = syncOut[4];
  assign echoSync = syncOut[5];

  // ---------------------------------------------------------------------------
  // Buttons
  // ---------------------------------------------------------------------------
  logic [3:0] pressPulse;

  for (genvar i = 0; i < 4; i++) begin : gDebounce
    tamagotchi_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebounce (
      .clk       (clk),
      .rst       (rst),
      .btnSync   (syncOut[i]),
      .pressPulse(pressPulse[i])
    );
  end

  assign feeding      = pressPulse[0];
  assign healing      = pressPulse[1];
  assign change_state = pressPulse[2];
  assign test         = pressPulse[3];

  // ---------------------------------------------------------------------------
  // Light: one pulse per LIGHT_HOLD_CYCLES of continuous darkness.
  // ---------------------------------------------------------------------------
  localparam int LIGHT_W = $clog2(LIGHT_HOLD_CYCLES > 1 ? LIGHT_HOLD_CYCLES : 2);
  localparam logic [LIGHT_W-1:0] LIGHT_LAST = LIGHT_W'(LIGHT_HOLD_CYCLES - 1);

  logic [LIGHT_W-1:0] darkCnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      darkCnt   <= '0;
      light_out <= 1'b0;
    end else begin
      light_out <= 1'b0;
      if (!ldrSync) begin
        darkCnt <= '0;
      end else if (darkCnt == LIGHT_LAST) begin
        darkCnt   <= '0;
        light_out <= 1'b1;
      end else begin
        darkCnt <= darkCnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ultrasonic ranging
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    EVAL
  } usStateT;

  localparam int PERIOD_W  = $clog2(MEAS_PERIOD_CYCLES > 1 ? MEAS_PERIOD_CYCLES : 2);
  localparam int PHASE_MAX = (TRIG_CYCLES > ECHO_TIMEOUT_CYCLES) ? TRIG_CYCLES
                                                                 : ECHO_TIMEOUT_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX > 1 ? PHASE_MAX : 2);
  localparam int WIDTH_W   = $clog2(ECHO_TIMEOUT_CYCLES + 1);

  localparam logic [PERIOD_W-1:0] PERIOD_LAST  = PERIOD_W'(MEAS_PERIOD_CYCLES - 1);
  localparam logic [PHASE_W-1:0]  TRIG_LAST    = PHASE_W'(TRIG_CYCLES - 1);
  localparam logic [PHASE_W-1:0]  TIMEOUT_LAST = PHASE_W'(ECHO_TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH_W-1:0]  WIDTH_MAX    = WIDTH_W'(ECHO_TIMEOUT_CYCLES);

  usStateT             state;
  usStateT             nextState;
  logic [PERIOD_W-1:0] periodCnt;
  logic [PHASE_W-1:0]  phaseCnt;   // cycles spent in TRIG or WAIT_ECHO
  logic [WIDTH_W-1:0]  widthCnt;   // echo high time seen in MEASURE
  logic                echoPrev;
  logic                periodWrap;
  logic                echoRise;
  logic                measNear;

  assign periodWrap = (periodCnt == PERIOD_LAST);
  assign echoRise   = echoSync & ~echoPrev;

  // A width that hit the timeout is far no matter how the thresholds compare.
  assign measNear = (widthCnt != '0) && (widthCnt != WIDTH_MAX) &&
                    (32'(widthCnt) < NEAR_THRESH_CYCLES);

  assign us_trig = (state == TRIG);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: nextState gets its default before the case so that no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:      if (periodWrap) nextState = TRIG;
      TRIG:      if (phaseCnt == TRIG_LAST) nextState = WAIT_ECHO;
      WAIT_ECHO: begin
        if (echoRise) begin
          nextState = MEASURE;
        end else if (phaseCnt == TIMEOUT_LAST) begin
          nextState = EVAL;
        end
      end
      MEASURE:   if (!echoSync || widthCnt == WIDTH_MAX) nextState = EVAL;
      EVAL:      nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // The period counter free-runs through measurements; a wrap seen outside
  // IDLE is simply not acted on, so that period produces no trigger.
  always_ff @(posedge clk) begin
    if (!rst) begin
      periodCnt <= '0;
      phaseCnt  <= '0;
      widthCnt  <= '0;
      echoPrev  <= 1'b0;
      near_flag <= 1'b0;
      echo_sig  <= 1'b0;
    end else begin
      periodCnt <= periodWrap ? '0 : periodCnt + 1'b1;
      echoPrev  <= echoSync;
      echo_sig  <= 1'b0;

      unique case (state)
        TRIG, WAIT_ECHO: phaseCnt <= (nextState != state) ? '0 : phaseCnt + 1'b1;
        default:         phaseCnt <= '0;
      endcase

      unique case (state)
        WAIT_ECHO: widthCnt <= '0;
        MEASURE:   if (echoSync && widthCnt != WIDTH_MAX) widthCnt <= widthCnt + 1'b1;
        EVAL: begin
          near_flag <= measNear;
          echo_sig  <= measNear & ~near_flag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tamagotchi_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_tamagotchi_input_conditioner
//
// Directed bench for tamagotchi_input_conditioner with small timing parameters.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, so sample k of a window shows the state after edge k.
// -----------------------------------------------------------------------------
module tb_tamagotchi_input_conditioner;

  localparam int DEB  = 4;
  localparam int LH   = 10;
  localparam int TRG  = 3;
  localparam int MP   = 200;
  localparam int TO   = 80;
  localparam int NT   = 20;

  localparam int I_FEED  = 0;
  localparam int I_HEAL  = 1;
  localparam int I_STATE = 2;
  localparam int I_TEST  = 3;
  localparam int I_LIGHT = 4;
  localparam int I_ECHO  = 5;
  localparam int I_TRIG  = 6;

  logic clk         = 1'b0;
  logic rst         = 1'b0;
  logic btn_feed_n  = 1'b1;
  logic btn_heal_n  = 1'b1;
  logic btn_state_n = 1'b1;
  logic btn_test_n  = 1'b1;
  logic ldr_dark    = 1'b0;
  logic us_echo     = 1'b0;
  logic us_trig;
  logic feeding;
  logic healing;
  logic change_state;
  logic test;
  logic light_out;
  logic echo_sig;
  logic near_flag;

  tamagotchi_input_conditioner #(
    .DEBOUNCE_CYCLES    (DEB),
    .LIGHT_HOLD_CYCLES  (LH),
    .TRIG_CYCLES        (TRG),
    .MEAS_PERIOD_CYCLES (MP),
    .ECHO_TIMEOUT_CYCLES(TO),
    .NEAR_THRESH_CYCLES (NT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_feed_n  (btn_feed_n),
    .btn_heal_n  (btn_heal_n),
    .btn_state_n (btn_state_n),
    .btn_test_n  (btn_test_n),
    .ldr_dark    (ldr_dark),
    .us_echo     (us_echo),
    .us_trig     (us_trig),
    .feeding     (feeding),
    .healing     (healing),
    .change_state(change_state),
    .test        (test),
    .light_out   (light_out),
    .echo_sig    (echo_sig),
    .near_flag   (near_flag)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int absCycle    = 0;
  int obsCycle    = 0;
  int refAbs      = 0;
  int pulseCnt[7];
  int firstAt[7];
  int lastAt[7];
  int prevAt[7];

  logic [6:0] obs;
  assign obs = {us_trig, echo_sig, light_out, test, change_state, healing, feeding};

  task automatic clearObs();
    obsCycle = 0;
    for (int i = 0; i < 7; i++) begin
      pulseCnt[i] = 0;
      firstAt[i]  = -1;
      lastAt[i]   = -1;
      prevAt[i]   = -1;
    end
  endtask

  // Advance n cycles, recording every high output sample.
  task automatic watch(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      absCycle++;
      obsCycle++;
      for (int i = 0; i < 7; i++) begin
        if (obs[i] === 1'b1) begin
          pulseCnt[i]++;
          if (firstAt[i] < 0) firstAt[i] = obsCycle;
          prevAt[i] = lastAt[i];
          lastAt[i] = obsCycle;
        end
      end
    end
  endtask

  task automatic applyReset();
    rst         = 1'b0;
    btn_feed_n  = 1'b1;
    btn_heal_n  = 1'b1;
    btn_state_n = 1'b1;
    btn_test_n  = 1'b1;
    ldr_dark    = 1'b0;
    us_echo     = 1'b0;
    watch(3);
    rst    = 1'b1;
    refAbs = absCycle;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_feed_n  = ~i[0];
      btn_heal_n  = ~i[0];
      btn_state_n = ~i[0];
      btn_test_n  = ~i[0];
      ldr_dark    = i[0];
      us_echo     = i[0];
      watch(1);
      vectors++;
      if ({obs, near_flag} !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %b, expected 00000000", i, {obs, near_flag});
      end
    end
    applyReset();
    watch(3);
    vectors++;
    if ({obs, near_flag} !== 8'h00) begin
      miscompares++;
      $display("FAIL post_release_outputs: got %b, expected 00000000", {obs, near_flag});
    end
  endtask

  task automatic test_debounce_glitch();
    clearObs();
    btn_feed_n = 1'b0;
    watch(3);
    btn_feed_n = 1'b1;
    watch(15);
    vectors++;
    if (pulseCnt[I_FEED] !== 0) begin
      miscompares++;
      $display("FAIL glitch_feed: got %0d pulses, expected 0", pulseCnt[I_FEED]);
    end
  endtask

  task automatic test_debounce_press();
    clearObs();
    btn_feed_n = 1'b0;
    watch(20);
    vectors++;
    if (pulseCnt[I_FEED] !== 1) begin
      miscompares++;
      $display("FAIL press_feed_count: got %0d pulses, expected 1", pulseCnt[I_FEED]);
    end
    vectors++;
    if (firstAt[I_FEED] !== 2 + DEB + 1) begin
      miscompares++;
      $display("FAIL press_feed_latency: got cycle %0d, expected %0d", firstAt[I_FEED], 2 + DEB + 1);
    end
    clearObs();
    btn_feed_n = 1'b1;
    watch(15);
    vectors++;
    if (pulseCnt[I_FEED] !== 0) begin
      miscompares++;
      $display("FAIL release_feed: got %0d pulses, expected 0", pulseCnt[I_FEED]);
    end
  endtask

  task automatic test_simultaneous();
    clearObs();
    btn_heal_n  = 1'b0;
    btn_state_n = 1'b0;
    watch(20);
    vectors++;
    if (pulseCnt[I_HEAL] !== 1 || pulseCnt[I_STATE] !== 1) begin
      miscompares++;
      $display("FAIL simul_counts: got heal=%0d state=%0d, expected 1 and 1",
               pulseCnt[I_HEAL], pulseCnt[I_STATE]);
    end
    vectors++;
    if (firstAt[I_HEAL] !== 7 || firstAt[I_STATE] !== 7) begin
      miscompares++;
      $display("FAIL simul_timing: got heal@%0d state@%0d, expected both @7",
               firstAt[I_HEAL], firstAt[I_STATE]);
    end
    vectors++;
    if (pulseCnt[I_FEED] !== 0 || pulseCnt[I_TEST] !== 0) begin
      miscompares++;
      $display("FAIL simul_crosstalk: got feed=%0d test=%0d, expected 0 and 0",
               pulseCnt[I_FEED], pulseCnt[I_TEST]);
    end
    btn_heal_n  = 1'b1;
    btn_state_n = 1'b1;
    watch(15);
  endtask

  task automatic test_test_button();
    clearObs();
    btn_test_n = 1'b0;
    watch(20);
    btn_test_n = 1'b1;
    watch(15);
    vectors++;
    if (pulseCnt[I_TEST] !== 1 || firstAt[I_TEST] !== 7) begin
      miscompares++;
      $display("FAIL test_button: got %0d pulses first@%0d, expected 1 pulse @7",
               pulseCnt[I_TEST], firstAt[I_TEST]);
    end
  endtask

  task automatic test_light_hold();
    clearObs();
    ldr_dark = 1'b1;
    watch(35);
    ldr_dark = 1'b0;
    watch(5);
    vectors++;
    if (pulseCnt[I_LIGHT] !== 3) begin
      miscompares++;
      $display("FAIL light_count: got %0d pulses, expected 3", pulseCnt[I_LIGHT]);
    end
    vectors++;
    if (firstAt[I_LIGHT] !== 12 || prevAt[I_LIGHT] !== 22 || lastAt[I_LIGHT] !== 32) begin
      miscompares++;
      $display("FAIL light_spacing: got @%0d,@%0d,@%0d, expected @12,@22,@32",
               firstAt[I_LIGHT], prevAt[I_LIGHT], lastAt[I_LIGHT]);
    end
  endtask

  task automatic test_light_interrupted();
    clearObs();
    ldr_dark = 1'b1;
    watch(9);
    ldr_dark = 1'b0;
    watch(1);
    ldr_dark = 1'b1;
    watch(9);
    ldr_dark = 1'b0;
    watch(5);
    vectors++;
    if (pulseCnt[I_LIGHT] !== 0) begin
      miscompares++;
      $display("FAIL light_interrupted: got %0d pulses, expected 0", pulseCnt[I_LIGHT]);
    end
  endtask

  // One full measurement period: wait for the trigger, answer with an echo of
  // the given raw width (0 = no echo), then check the outcome.
  task automatic measure(input string name, input int width, input bit expNear,
                         input int expPulse, input int expGap);
    bit seen;
    int waited;
    clearObs();
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < MP + 50) begin
      watch(1);
      waited++;
      if (us_trig === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s_trig_timeout: got no trigger in %0d cycles, expected one", name, waited);
    end else begin
      vectors++;
      if (absCycle - refAbs !== expGap) begin
        miscompares++;
        $display("FAIL %s_trig_gap: got %0d cycles, expected %0d", name, absCycle - refAbs, expGap);
      end
      refAbs = absCycle;
      watch(4);
      if (width > 0) begin
        us_echo = 1'b1;
        watch(width);
        us_echo = 1'b0;
      end
      watch(100);
      vectors++;
      if (pulseCnt[I_TRIG] !== TRG) begin
        miscompares++;
        $display("FAIL %s_trig_width: got %0d cycles, expected %0d", name, pulseCnt[I_TRIG], TRG);
      end
      vectors++;
      if (pulseCnt[I_ECHO] !== expPulse) begin
        miscompares++;
        $display("FAIL %s_echo_sig: got %0d pulses, expected %0d", name, pulseCnt[I_ECHO], expPulse);
      end
      vectors++;
      if (near_flag !== expNear) begin
        miscompares++;
        $display("FAIL %s_near_flag: got %b, expected %b", name, near_flag, expNear);
      end
    end
  endtask

  task automatic test_ultrasonic();
    applyReset();
    measure("near1",   15, 1'b1, 1, MP);
    measure("near2",   15, 1'b1, 0, MP);
    measure("far",     50, 1'b0, 0, MP);
    measure("near3",   15, 1'b1, 1, MP);
    measure("timeout",  0, 1'b0, 0, MP);
    measure("near4",   15, 1'b1, 1, MP);
  endtask

  task automatic test_reset_mid_measure();
    bit seen;
    int waited;
    clearObs();
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < MP + 50) begin
      watch(1);
      waited++;
      if (us_trig === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL midrst_trig_timeout: got no trigger in %0d cycles, expected one", waited);
    end
    watch(4);
    us_echo = 1'b1;
    watch(10);
    rst = 1'b0;
    clearObs();
    watch(3);
    vectors++;
    if (pulseCnt[I_TRIG] !== 0 || pulseCnt[I_ECHO] !== 0 || near_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got trig=%0d echo=%0d near=%b, expected 0 0 0",
               pulseCnt[I_TRIG], pulseCnt[I_ECHO], near_flag);
    end
    us_echo = 1'b0;
    rst     = 1'b1;
    refAbs  = absCycle;
    measure("post_reset", 0, 1'b0, 0, MP);
    measure("post_near", 15, 1'b1, 1, MP);
  endtask

  initial begin
    test_reset();
    test_debounce_glitch();
    test_debounce_press();
    test_simultaneous();
    test_test_button();
    test_light_hold();
    test_light_interrupted();
    test_ultrasonic();
    test_reset_mid_measure();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit, expected bench completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/tamagotchi_input_conditioner.md
Name: tamagotchi_input_conditioner

Overview:
- Front-end stage directly upstream of the pet-state FSM.
- Converts raw board inputs into clean single-cycle `clk` pulses that the state FSM consumes: `feeding`, `healing`, `change_state`, `test`, `light_out` and `echo_sig`.
  - Raw inputs are four active-low push buttons, a photoresistor comparator and an HC-SR04 ultrasonic sensor.
- Also drives the ultrasonic trigger and reports a proximity level.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button change (20 ms at 50 MHz).
- LIGHT_HOLD_CYCLES, 25000000, continuous-dark cycles per `light_out` pulse (0.5 s).
- TRIG_CYCLES, 500, `us_trig` high width (10 us).
- MEAS_PERIOD_CYCLES, 3000000, cycles between successive trigger starts (60 ms).
- ECHO_TIMEOUT_CYCLES, 1500000, maximum wait for echo rise, and separately maximum echo width (30 ms).
- NEAR_THRESH_CYCLES, 29000, echo width below which the object counts as near (~10 cm).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-low
- btn_feed_n  in  1  raw feed button, 0 = pressed
- btn_heal_n  in  1  raw heal button, 0 = pressed
- btn_state_n  in  1  raw select-stat button, 0 = pressed
- btn_test_n  in  1  raw test-mode toggle button, 0 = pressed
- ldr_dark  in  1  raw photoresistor comparator, 1 = dark
- us_echo  in  1  raw ultrasonic echo
- us_trig  out  1  ultrasonic trigger
- feeding  out  1  one-cycle pulse on feed press
- healing  out  1  one-cycle pulse on heal press
- change_state  out  1  one-cycle pulse on select press
- test  out  1  one-cycle pulse on test press
- light_out  out  1  one-cycle pulse per completed dark hold period
- echo_sig  out  1  one-cycle pulse on far-to-near transition
- near_flag  out  1  level, result of the last completed measurement

Behaviour:

Reset:
- Reset is clk and rst: synchronous, active-low.
- While rst == 0:
  - all outputs are 0; `us_trig` = 0;
  - synchronizers load the inactive level;
  - debounced states are "released";
  - all counters are 0;
  - ultrasonic FSM is in IDLE.
- Reset asserted mid-measurement aborts it on the next edge; no pulse is emitted.

Synchronization:
- Every raw input passes through a 2-FF synchronizer before any use.

Button debounce (four identical instances):
- Each instance keeps a `stable` bit and a counter.
- When the synchronized input equals `stable`, the counter is cleared.
- When it differs, the counter increments.
- When the counter reaches DEBOUNCE_CYCLES-1, `stable` takes the new value and the counter clears.
- The output pulse is high exactly one cycle, in the cycle after `stable` goes released to pressed.
- Release produces no pulse.
- Latency from raw press: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Simultaneous presses on different buttons produce independent, coincident pulses.

Light:
- The dark counter increments while synchronized `ldr_dark` = 1 and clears when it is 0.
- On reaching LIGHT_HOLD_CYCLES-1: `light_out` pulses one cycle and the counter wraps to 0, repeating while dark persists.
- Going light mid-count clears the counter with no pulse.

Ultrasonic FSM:
- A period counter runs from 0 to MEAS_PERIOD_CYCLES-1 and then wraps.
- States and transitions:
  - IDLE: go to TRIG when the period counter wraps to 0.
  - TRIG: `us_trig` = 1 for exactly TRIG_CYCLES cycles, then go to WAIT_ECHO.
  - WAIT_ECHO: rising edge of synchronized echo → MEASURE, with the width counter at 0. ECHO_TIMEOUT_CYCLES elapsed → EVAL with result far.
  - MEASURE: the width counter increments while echo = 1. Echo fall → EVAL. Width reaching ECHO_TIMEOUT_CYCLES → EVAL with result far.
  - EVAL: one cycle. near = (width > 0) && (width < NEAR_THRESH_CYCLES). `near_flag` <= near. Then go to IDLE.
- `echo_sig` pulses one cycle, in the cycle after EVAL, only when `near_flag` changes 0 to 1.
- Staying near across measurements gives no further pulses.
- The first trigger starts MEAS_PERIOD_CYCLES cycles after reset release.
- The period counter keeps running during a measurement. A wrap that occurs while not in IDLE is ignored; that period is skipped.

Counter widths:
- Sized with $clog2 of their limit.
- No counter overflows or saturates beyond its stated limit.

Test Plan:
- Use sim parameters DEBOUNCE=4, LIGHT_HOLD=10, TRIG=3, MEAS_PERIOD=200, TIMEOUT=80, NEAR_THRESH=20.
- Reset: hold rst=0 for 5 cycles with all raw inputs toggling → every output stays 0; `near_flag`=0.
- Debounce: `btn_feed_n` low for 3 cycles then high → no `feeding` pulse. Low for 20 cycles → exactly one `feeding` pulse at cycle 2+4+1=7 after the fall. Release → no pulse.
- Simultaneous buttons: `btn_heal_n` and `btn_state_n` fall together and stay low → `healing` and `change_state` each pulse once, in the same cycle.
- Light: `ldr_dark`=1 for 35 cycles → exactly 3 `light_out` pulses spaced 10 cycles apart. Dark 9 cycles, light 1, dark 9 → 0 pulses.
- Ultrasonic near/far:
  - echo width 15 → `near_flag`=1 and one `echo_sig` pulse;
  - next measurement width 15 → no pulse;
  - next width 50 → `near_flag`=0;
  - next width 15 → pulse again;
  - check that `us_trig` is high exactly 3 cycles per period.
- Timeout/reset: no echo for 80 cycles after trigger → `near_flag`=0 and FSM back in IDLE. rst=0 during MEASURE → `us_trig`=0, no `echo_sig`, next trigger 200 cycles after release.
